scaler_in_seq: RTL

Frame sequencer in front of `scaler`. It pulls pixels from a valid/ready source, such as a frame-buffer reader. It then drives the scaler's input-side controls: `iVsyn`, `iHsyn`, `dIn`, `dInEn` and `en`. It also presents a frame-stable copy of the resolution and crop registers to the scaler. Configuration is latched only at frame start, so software can rewrite it at any time without tearing a frame.

---
 rtl/scaler_pkg.sv | 42 ++++
 rtl/scaler_cfg_shadow.sv | 24 ++
 rtl/scaler_in_seq.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/scaler_pkg.sv
// Shared types and defaults for the scaler input-side sequencer:
// state encoding, default widths, and the resolution/crop config bundle.
package scaler_pkg;

  localparam int unsigned DEF_DATA_WIDTH      = 24;
  localparam int unsigned INPUT_RES_WIDTH     = 11;
  localparam int unsigned DEF_FRAME_CNT_WIDTH = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_VSYNC = 3'd1,
    ST_PIX   = 3'd2,
    ST_HSYNC = 3'd3,
    ST_FDONE = 3'd4
  } state_t;

  typedef logic [INPUT_RES_WIDTH-1:0] res_t;

  typedef struct packed {
    res_t in_x_res;
    res_t in_y_res;
    res_t out_x_res;
    res_t out_y_res;
    res_t x_bgn;
    res_t x_end;
    res_t y_bgn;
    res_t y_end;
  } scaler_cfg;

  // A config is usable when all resolutions are non-zero and the crop
  // window is ordered and lies inside the input frame.
  function automatic logic cfg_is_valid(input scaler_cfg c);
    logic v;
    v = 1'b1;
    if (c.in_x_res == '0 || c.in_y_res == '0)   v = 1'b0;
    if (c.out_x_res == '0 || c.out_y_res == '0) v = 1'b0;
    if (c.x_bgn > c.x_end || c.x_end >= c.in_x_res) v = 1'b0;
    if (c.y_bgn > c.y_end || c.y_end >= c.in_y_res) v = 1'b0;
    return v;
  endfunction

endpackage

// File: rtl/scaler_cfg_shadow.sv
// Validity check and frame-stable shadow bank for the resolution/crop config.
// The shadow only changes on load, so the scaler never sees a torn frame.
module scaler_cfg_shadow
  import scaler_pkg::*;
(
  input  logic      clka,
  input  logic      rst_n,
  input  logic      load,
  input  scaler_cfg cfg_in,
  output logic      ok,
  output scaler_cfg cfg_q
);

  assign ok = cfg_is_valid(cfg_in);

  always_ff @(posedge clka) begin
    if (!rst_n) begin
      cfg_q <= '0;
    end else if (load) begin
      cfg_q <= cfg_in;
    end
  end

endmodule

// File: rtl/scaler_in_seq.sv
// Frame sequencer feeding the scaler input: pulls pixels from a valid/ready
// source and generates vsync/hsync/pixel strobes with frame-latched config.
module scaler_in_seq
  import scaler_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int unsigned FRAME_CNT_WIDTH = DEF_FRAME_CNT_WIDTH
) (
  input  logic                       clka,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       stop,
  input  logic [FRAME_CNT_WIDTH-1:0] cfgNumFrames,
  input  logic [INPUT_RES_WIDTH-1:0] cfgInXRes,
  input  logic [INPUT_RES_WIDTH-1:0] cfgInYRes,
  input  logic [INPUT_RES_WIDTH-1:0] cfgOutXRes,
  input  logic [INPUT_RES_WIDTH-1:0] cfgOutYRes,
  input  logic [INPUT_RES_WIDTH-1:0] cfgXBgn,
  input  logic [INPUT_RES_WIDTH-1:0] cfgXEnd,
  input  logic [INPUT_RES_WIDTH-1:0] cfgYBgn,
  input  logic [INPUT_RES_WIDTH-1:0] cfgYEnd,
  input  logic [DATA_WIDTH-1:0]      srcData,
  input  logic                       srcValid,
  output logic                       srcReady,
  output logic [DATA_WIDTH-1:0]      dIn,
  output logic                       dInEn,
  output logic                       iHsyn,
  output logic                       iVsyn,
  output logic                       en,
  output logic [INPUT_RES_WIDTH-1:0] inXRes,
  output logic [INPUT_RES_WIDTH-1:0] inYRes,
  output logic [INPUT_RES_WIDTH-1:0] outXRes,
  output logic [INPUT_RES_WIDTH-1:0] outYRes,
  output logic [INPUT_RES_WIDTH-1:0] xBgn,
  output logic [INPUT_RES_WIDTH-1:0] xEnd,
  output logic [INPUT_RES_WIDTH-1:0] yBgn,
  output logic [INPUT_RES_WIDTH-1:0] yEnd,
  output logic                       busy,
  output logic                       frameDone,
  output logic [FRAME_CNT_WIDTH-1:0] frameCnt,
  output logic                       cfgErr
);

  state_t    state, state_nxt;
  res_t      x, y, x_d, y_d, y_inc;
  scaler_cfg cfg_in, cfg_sh;
  logic      cfg_ok, cfg_load;
  logic      accept, reject, hs, last_pix, run_end;
  logic      stop_pend, stop_pend_d;
  logic [FRAME_CNT_WIDTH-1:0] num_frames, frame_cnt_d;
  logic [DATA_WIDTH-1:0]      din_d;
  logic      cfg_err_d;

  assign cfg_in = '{in_x_res: cfgInXRes, in_y_res: cfgInYRes,
                    out_x_res: cfgOutXRes, out_y_res: cfgOutYRes,
                    x_bgn: cfgXBgn, x_end: cfgXEnd,
                    y_bgn: cfgYBgn, y_end: cfgYEnd};

  scaler_cfg_shadow u_shadow (
    .clka   (clka),
    .rst_n  (rst_n),
    .load   (cfg_load),
    .cfg_in (cfg_in),
    .ok     (cfg_ok),
    .cfg_q  (cfg_sh)
  );

  assign inXRes  = cfg_sh.in_x_res;
  assign inYRes  = cfg_sh.in_y_res;
  assign outXRes = cfg_sh.out_x_res;
  assign outYRes = cfg_sh.out_y_res;
  assign xBgn    = cfg_sh.x_bgn;
  assign xEnd    = cfg_sh.x_end;
  assign yBgn    = cfg_sh.y_bgn;
  assign yEnd    = cfg_sh.y_end;

  assign srcReady = (state == ST_PIX);
  assign hs       = srcReady & srcValid;
  assign last_pix = hs && (x == cfg_sh.in_x_res - res_t'(1));
  assign y_inc    = y + res_t'(1);
  assign accept   = (state == ST_IDLE) && start && cfg_ok;
  assign reject   = (state == ST_IDLE) && start && !cfg_ok;
  assign run_end  = stop_pend ||
                    ((num_frames != '0) && (frameCnt == num_frames));

  always_ff @(posedge clka) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept) state_nxt = ST_VSYNC;
      ST_VSYNC: state_nxt = ST_PIX;
      ST_PIX:   if (last_pix) state_nxt = ST_HSYNC;
      ST_HSYNC: state_nxt = (y_inc == cfg_sh.in_y_res) ? ST_FDONE : ST_PIX;
      ST_FDONE: state_nxt = run_end ? ST_IDLE : ST_VSYNC;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Next values for the registered outputs, counters and the stop request.
  always_comb begin
    x_d         = x;
    y_d         = y;
    din_d       = dIn;
    frame_cnt_d = frameCnt;
    cfg_err_d   = cfgErr;
    stop_pend_d = stop_pend | stop;
    cfg_load    = 1'b0;
    if (hs) din_d = srcData;
    case (state)
      ST_IDLE: begin
        stop_pend_d = accept & stop;
        if (accept) begin
          cfg_load    = 1'b1;
          frame_cnt_d = '0;
          cfg_err_d   = 1'b0;
        end else if (reject) begin
          cfg_err_d   = 1'b1;
        end
      end
      ST_VSYNC: begin
        x_d = '0;
        y_d = '0;
      end
      ST_PIX: if (hs) x_d = x + res_t'(1);
      ST_HSYNC: begin
        x_d = '0;
        y_d = y_inc;
        if (state_nxt == ST_FDONE && !(&frameCnt))
          frame_cnt_d = frameCnt + FRAME_CNT_WIDTH'(1);
      end
      ST_FDONE: begin
        stop_pend_d = stop & (state_nxt != ST_IDLE);
        cfg_load    = (state_nxt == ST_VSYNC);
      end
      default: ;
    endcase
  end

  // hsync trails the HSYNC state by one cycle so it follows the line's last dInEn.
  always_ff @(posedge clka) begin
    if (!rst_n) begin
      x          <= '0;
      y          <= '0;
      dIn        <= '0;
      dInEn      <= 1'b0;
      iVsyn      <= 1'b0;
      iHsyn      <= 1'b0;
      en         <= 1'b0;
      busy       <= 1'b0;
      frameDone  <= 1'b0;
      frameCnt   <= '0;
      cfgErr     <= 1'b0;
      stop_pend  <= 1'b0;
      num_frames <= '0;
    end else begin
      x          <= x_d;
      y          <= y_d;
      dIn        <= din_d;
      dInEn      <= hs;
      iVsyn      <= (state_nxt == ST_VSYNC);
      iHsyn      <= (state == ST_HSYNC);
      en         <= (state_nxt != ST_IDLE);
      busy       <= (state_nxt != ST_IDLE);
      frameDone  <= (state_nxt == ST_FDONE);
      frameCnt   <= frame_cnt_d;
      cfgErr     <= cfg_err_d;
      stop_pend  <= stop_pend_d;
      if (cfg_load) num_frames <= cfgNumFrames;
    end
  end

endmodule
